video_timing_gen: RTL and testbench



---
 rtl/video_timing_gen_if.sv | 24 ++
 rtl/video_timing_gen.sv | 95 +++++++++
 tb/tb_video_timing_gen.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// Video bus between timing generator, object compositor and TMDS encoder.
// master = timing generator; slave = compositor/encoder side.
interface video_timing_gen_if;
  logic signed [11:0] hpos;
  logic signed [11:0] vpos;
  logic               fsync;
  logic               hsync;
  logic               vsync;
  logic               de;
  logic [2:0][7:0]    rgb;
  logic [2:0][7:0]    pixel_in;

  modport master (
    output hpos, vpos, fsync,
    output hsync, vsync, de, rgb,
    input  pixel_in
  );

  modport slave (
    input  hpos, vpos, fsync,
    input  hsync, vsync, de, rgb,
    output pixel_in
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing source: signed scan coordinates, fsync, registered video.
// Optional macro TEST_PATTERN_EN adds test_mode colour bars.
module video_timing_gen #(
  parameter int HRES   = 1280,
  parameter int H_FP   = 110,
  parameter int H_SYNC = 40,
  parameter int H_BP   = 220,
  parameter int VRES   = 720,
  parameter int V_FP   = 5,
  parameter int V_SYNC = 5,
  parameter int V_BP   = 20,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1
) (
  input  logic pixel_clk,
  input  logic rst_n,
`ifdef TEST_PATTERN_EN
  input  logic test_mode,
`endif
  video_timing_gen_if.master vid
);
  localparam int HBLANK = H_FP + H_SYNC + H_BP;
  localparam int VBLANK = V_FP + V_SYNC + V_BP;

  localparam logic signed [11:0] H_FIRST = 12'(-HBLANK);
  localparam logic signed [11:0] H_LAST  = 12'(HRES - 1);
  localparam logic signed [11:0] HS_LO   = 12'(-(H_SYNC + H_BP));
  localparam logic signed [11:0] HS_HI   = 12'(-H_BP - 1);
  localparam logic signed [11:0] V_FIRST = 12'(-VBLANK);
  localparam logic signed [11:0] V_LAST  = 12'(VRES - 1);
  localparam logic signed [11:0] VS_LO   = 12'(-(V_SYNC + V_BP));
  localparam logic signed [11:0] VS_HI   = 12'(-V_BP - 1);

  logic signed [11:0] hpos;
  logic signed [11:0] vpos;
  logic               h_end;
  logic               v_end;
  logic               hs_on;
  logic               vs_on;
  logic               active;
  logic [2:0][7:0]    pix;

  assign h_end  = (hpos == H_LAST);
  assign v_end  = (vpos == V_LAST);
  assign hs_on  = (hpos >= HS_LO) && (hpos <= HS_HI);
  assign vs_on  = (vpos >= VS_LO) && (vpos <= VS_HI);
  assign active = !hpos[11] && !vpos[11];

`ifdef TEST_PATTERN_EN
  logic [14:0]     scaled;
  logic [2:0]      bar;
  logic [2:0][7:0] bars;

  assign scaled = {hpos, 3'b000};
  assign bar    = 3'(scaled / 15'(HRES));
  // white,yellow,cyan,green,magenta,red,blue,black: R=~b1 G=~b2 B=~b0
  assign bars   = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
  assign pix    = test_mode ? bars : vid.pixel_in;
`else
  assign pix    = vid.pixel_in;
`endif

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos      <= H_FIRST;
      vpos      <= V_FIRST;
      vid.fsync <= 1'b0;
    end else begin
      vid.fsync <= h_end && v_end;
      if (h_end) begin
        hpos <= H_FIRST;
        vpos <= v_end ? V_FIRST : vpos + 12'sd1;
      end else begin
        hpos <= hpos + 12'sd1;
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      vid.hsync <= ~HS_POL;
      vid.vsync <= ~VS_POL;
      vid.de    <= 1'b0;
      vid.rgb   <= '0;
    end else begin
      vid.hsync <= hs_on ? HS_POL : ~HS_POL;
      vid.vsync <= vs_on ? VS_POL : ~VS_POL;
      vid.de    <= active;
      vid.rgb   <= active ? pix : '0;
    end
  end

  assign vid.hpos = hpos;
  assign vid.vpos = vpos;
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small-raster reference model checks,
// plus a full-size colour bar check when TEST_PATTERN_EN is defined.
`timescale 1ns/1ps
module tb_video_timing_gen;
  localparam int HRES = 16, H_FP = 2, H_SYNC = 3, H_BP = 4;
  localparam int VRES = 8, V_FP = 1, V_SYNC = 2, V_BP = 3;
  localparam int HB = H_FP + H_SYNC + H_BP;
  localparam int VB = V_FP + V_SYNC + V_BP;
  localparam int HT = HRES + HB;
  localparam int VT = VRES + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tm1 = 1'b0;
  int tests = 0;
  int fails = 0;
  int t = 0;
  logic [23:0] pix_edge = '0;

  always #5 clk = ~clk;

  video_timing_gen_if vid();

  video_timing_gen #(
    .HRES(HRES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .VRES(VRES), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .pixel_clk(clk),
    .rst_n(rst_n),
`ifdef TEST_PATTERN_EN
    .test_mode(tm1),
`endif
    .vid(vid)
  );

`ifdef TEST_PATTERN_EN
  logic rst2_n = 1'b0;
  logic tm2 = 1'b1;
  video_timing_gen_if vid2();
  video_timing_gen dut2 (
    .pixel_clk(clk),
    .rst_n(rst2_n),
    .test_mode(tm2),
    .vid(vid2)
  );
  logic [23:0] bars [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };
`endif

  // Frame index n = clocks since reset release, modulo frame length.
  function automatic int mh(int n);
    return (n % HT) - HB;
  endfunction
  function automatic int mv(int n);
    return ((n / HT) % VT) - VB;
  endfunction
  function automatic bit mhs(int n);
    int p = n % HT;
    return p >= H_FP && p < H_FP + H_SYNC;
  endfunction
  function automatic bit mvs(int n);
    int l = (n / HT) % VT;
    return l >= V_FP && l < V_FP + V_SYNC;
  endfunction
  function automatic bit mact(int n);
    return (n % HT) >= HB && ((n / HT) % VT) >= VB;
  endfunction

  task automatic step();
    pix_edge = vid.pixel_in;
    @(posedge clk);
    if (rst_n) t++;
    #1;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vid.pixel_in = 24'hA5A5A5;
    repeat (3) begin
      @(posedge clk);
      #1;
      tests++;
      if ({vid.hpos, vid.vpos} !== {12'(-HB), 12'(-VB)}) begin
        fails++;
        $display("FAIL reset_pos got %0d,%0d want %0d,%0d",
                 vid.hpos, vid.vpos, -HB, -VB);
      end
      tests++;
      if ({vid.fsync, vid.hsync, vid.vsync, vid.de, vid.rgb}
          !== 28'h0) begin
        fails++;
        $display("FAIL reset_out got fs%b hs%b vs%b de%b rgb%h want 0",
                 vid.fsync, vid.hsync, vid.vsync, vid.de, vid.rgb);
      end
    end
    release_rst();
  endtask

  task automatic test_random_frames();
    int n, p;
    logic [23:0] ergb;
    for (int i = 0; i < 2 * FT + 10; i++) begin
      vid.pixel_in = 24'($urandom);
      step();
      n = t % FT;
      p = (t - 1) % FT;
      tests++;
      if ({vid.hpos, vid.vpos, vid.fsync} !==
          {12'(mh(n)), 12'(mv(n)), (n == 0)}) begin
        fails++;
        $display("FAIL rand_pos t=%0d got %0d,%0d,%b want %0d,%0d,%b",
                 t, vid.hpos, vid.vpos, vid.fsync,
                 mh(n), mv(n), n == 0);
      end
      ergb = mact(p) ? pix_edge : 24'h0;
      tests++;
      if ({vid.hsync, vid.vsync, vid.de, vid.rgb} !==
          {mhs(p), mvs(p), mact(p), ergb}) begin
        fails++;
        $display("FAIL rand_vid t=%0d got %b%b%b %h want %b%b%b %h",
                 t, vid.hsync, vid.vsync, vid.de, vid.rgb,
                 mhs(p), mvs(p), mact(p), ergb);
      end
    end
  endtask

  task automatic test_line_wrap();
    bit found = 0;
    int v0, hs_cnt, first_h;
    for (int i = 0; i < 2 * HT && !found; i++) begin
      step();
      found = (vid.hpos == 12'(HRES - 1));
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL wrap_find got no hpos=%0d want one", HRES - 1);
    end
    v0 = int'(vid.vpos);
    step();
    tests++;
    if ({vid.hpos, vid.vpos} !==
        {12'(-HB), 12'(v0 == VRES - 1 ? -VB : v0 + 1)}) begin
      fails++;
      $display("FAIL wrap_step got %0d,%0d want %0d,%0d",
               vid.hpos, vid.vpos, -HB, v0 + 1);
    end
    hs_cnt = 0;
    first_h = 999;
    for (int i = 0; i < HT; i++) begin
      step();
      if (vid.hsync) begin
        if (hs_cnt == 0) first_h = int'(vid.hpos);
        hs_cnt++;
      end
    end
    tests++;
    if (hs_cnt != H_SYNC || first_h != -(H_SYNC + H_BP) + 1) begin
      fails++;
      $display("FAIL hsync_width got %0d first@%0d want %0d first@%0d",
               hs_cnt, first_h, H_SYNC, -(H_SYNC + H_BP) + 1);
    end
  endtask

  task automatic test_pipeline();
    int n, p;
    logic [23:0] ergb;
    int hits = 0;
    for (int i = 0; i < FT + 5; i++) begin
      n = t % FT;
      if (mh(n) == 3 && mv(n) == 2) vid.pixel_in = 24'hEFE62E;
      else if (!mact(n)) vid.pixel_in = 24'($urandom) | 24'h1;
      else vid.pixel_in = 24'h0;
      step();
      p = (t - 1) % FT;
      ergb = (mh(p) == 3 && mv(p) == 2) ? 24'hEFE62E : 24'h0;
      if (ergb != 0) hits++;
      tests++;
      if ({vid.de, vid.rgb} !== {mact(p), ergb}) begin
        fails++;
        $display("FAIL pipe_rgb at %0d,%0d got de%b %h want de%b %h",
                 mh(p), mv(p), vid.de, vid.rgb, mact(p), ergb);
      end
    end
    tests++;
    if (hits != 1) begin
      fails++;
      $display("FAIL pipe_hit got %0d want 1", hits);
    end
  endtask

  task automatic test_frame();
    int pulses = 0, vs_cnt = 0, last = 0, bad = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    release_rst();
    for (int i = 0; i < 3 * FT + 5; i++) begin
      vid.pixel_in = 24'($urandom);
      step();
      if (t <= FT && vid.vsync) vs_cnt++;
      if (vid.fsync) begin
        if (t - last != FT) bad++;
        last = t;
        pulses++;
      end
    end
    tests++;
    if (pulses != 3 || bad != 0) begin
      fails++;
      $display("FAIL fsync_period got %0d pulses %0d bad want 3 0",
               pulses, bad);
    end
    tests++;
    if (vs_cnt != V_SYNC * HT) begin
      fails++;
      $display("FAIL vsync_width got %0d want %0d", vs_cnt, V_SYNC * HT);
    end
  endtask

  task automatic test_async_reset();
    bit found = 0;
    int early = 0;
    vid.pixel_in = 24'h123456;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      step();
      found = (vid.hpos == 12'sd5 && vid.vpos == 12'sd4);
    end
    tests++;
    if (!found || vid.de !== 1'b1) begin
      fails++;
      $display("FAIL arst_find got found=%b de=%b want 1 1",
               found, vid.de);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({vid.hpos, vid.vpos} !== {12'(-HB), 12'(-VB)} ||
        {vid.fsync, vid.hsync, vid.vsync, vid.de, vid.rgb}
        !== 28'h0) begin
      fails++;
      $display("FAIL arst_now got %0d,%0d de%b rgb%h want %0d,%0d 0 0",
               vid.hpos, vid.vpos, vid.de, vid.rgb, -HB, -VB);
    end
    repeat (2) @(posedge clk);
    release_rst();
    for (int i = 0; i < FT - 1; i++) begin
      step();
      if (vid.fsync) early++;
    end
    tests++;
    if (early != 0) begin
      fails++;
      $display("FAIL arst_nofs got %0d pulses want 0", early);
    end
    step();
    tests++;
    if (vid.fsync !== 1'b1) begin
      fails++;
      $display("FAIL arst_fs got %b want 1 at t=%0d", vid.fsync, FT);
    end
  endtask

`ifdef TEST_PATTERN_EN
  task automatic test_pattern();
    bit found = 0;
    logic [23:0] ex;
    rst2_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst2_n = 1'b1;
    for (int i = 0; i < 60000 && !found; i++) begin
      vid2.pixel_in = 24'($urandom) | 24'h1;
      @(posedge clk);
      #1;
      found = (vid2.hpos == 12'sd0 && vid2.vpos == 12'sd0);
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL tp_find got timeout want hpos=0 vpos=0");
    end
    for (int i = 0; i < 1284; i++) begin
      vid2.pixel_in = 24'($urandom) | 24'h1;
      @(posedge clk);
      #1;
      ex = (i < 1280) ? bars[(i * 8) / 1280] : 24'h0;
      tests++;
      if (vid2.rgb !== ex) begin
        fails++;
        $display("FAIL tp_bar h=%0d got %h want %h", i, vid2.rgb, ex);
      end
    end
  endtask
`endif

  initial begin
    vid.pixel_in = '0;
`ifdef TEST_PATTERN_EN
    vid2.pixel_in = '0;
`endif
    test_reset();
    test_random_frames();
    test_line_wrap();
    test_pipeline();
    test_frame();
    test_async_reset();
`ifdef TEST_PATTERN_EN
    test_pattern();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
